// File: rtl/step_dir_decoder_if.sv
// Signal bundle between step/dir pins, the decoder and its consumer.
// The decoder uses the slave view; stimulus or pin logic uses the master view.
interface step_dir_decoder_if #(
  parameter int AXES = 8
);
  logic [AXES-1:0]       step_in;
  logic [AXES-1:0]       dir_in;
  logic [AXES-1:0]       clr_pos;
  logic                  err_clr;
  logic [AXES-1:0]       step_evt;
  logic [AXES-1:0][31:0] pos;
  logic [AXES-1:0][31:0] period;
  logic [AXES-1:0]       setup_err;

  modport master (
    output step_in, dir_in, clr_pos, err_clr,
    input  step_evt, pos, period, setup_err
  );

  modport slave (
    input  step_in, dir_in, clr_pos, err_clr,
    output step_evt, pos, period, setup_err
  );
endinterface

// File: rtl/step_dir_decoder.sv
// Multi-axis step/dir receiver: glitch-filtered inputs, signed position,
// step period measurement and sticky dir-setup violation flags per axis.
module step_dir_decoder #(
  parameter int AXES      = 8,
  parameter int FILT      = 3,
  parameter int DIR_SETUP = 4
) (
  input  logic            clk,
  input  logic            aclr,
  step_dir_decoder_if.slave bus
);

  localparam int LINES = 2 * AXES;
  localparam logic [3:0]  FILT_LAST = 4'(FILT - 1);
  localparam logic [7:0]  DIR_MAX   = 8'(DIR_SETUP);
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  // Step lines occupy the low half, dir lines the high half.
  logic [LINES-1:0] raw_s;
  logic [LINES-1:0] sync1_r;
  logic [LINES-1:0] sync2_r;
  logic [LINES-1:0] filt_s;
  logic [LINES-1:0] tog_s;
  logic [AXES-1:0]  step_filt_s;
  logic [AXES-1:0]  dir_filt_s;
  logic [AXES-1:0]  dir_tog_s;

  assign raw_s       = {bus.dir_in, bus.step_in};
  assign step_filt_s = filt_s[AXES-1:0];
  assign dir_filt_s  = filt_s[LINES-1:AXES];
  assign dir_tog_s   = tog_s[LINES-1:AXES];

  // Two-stage synchronizer for every raw line.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sync1_r <= {LINES{1'b0}};
      sync2_r <= {LINES{1'b0}};
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  for (genvar l = 0; l < LINES; l++) begin : g_filt
    logic [3:0] cnt_r;
    logic       filt_r;

    // The filtered value only follows after FILT consecutive differing samples.
    assign tog_s[l]  = (sync2_r[l] != filt_r) && (cnt_r == FILT_LAST);
    assign filt_s[l] = filt_r;

    // Glitch filter counter and filtered output.
    always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
        cnt_r  <= 4'd0;
        filt_r <= 1'b0;
      end else if (sync2_r[l] == filt_r) begin
        cnt_r <= 4'd0;
      end else if (cnt_r == FILT_LAST) begin
        cnt_r  <= 4'd0;
        filt_r <= ~filt_r;
      end else begin
        cnt_r <= cnt_r + 4'd1;
      end
    end
  end

  for (genvar i = 0; i < AXES; i++) begin : g_axis
    logic        step_d_r;
    logic        evt_r;
    logic        err_r;
    logic [31:0] pos_r;
    logic [31:0] per_r;
    logic [31:0] cnt_r;
    logic [7:0]  age_r;
    logic        rise_s;
    logic [31:0] delta_s;

    assign rise_s  = step_filt_s[i] & ~step_d_r;
    assign delta_s = dir_filt_s[i] ? 32'h0000_0001 : 32'hFFFF_FFFF;

    assign bus.step_evt[i]  = evt_r;
    assign bus.pos[i]       = pos_r;
    assign bus.period[i]    = per_r;
    assign bus.setup_err[i] = err_r;

    // Edge detect, position, period and dir-setup tracking for one axis.
    always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
        step_d_r <= 1'b0;
        evt_r    <= 1'b0;
        err_r    <= 1'b0;
        pos_r    <= 32'h0000_0000;
        per_r    <= CNT_MAX;
        cnt_r    <= CNT_MAX;
        age_r    <= DIR_MAX;
      end else begin
        step_d_r <= step_filt_s[i];
        evt_r    <= rise_s;

        // A clear coinciding with a step lands on +/-1 so the step survives.
        if (bus.clr_pos[i]) begin
          pos_r <= rise_s ? delta_s : 32'h0000_0000;
        end else if (rise_s) begin
          pos_r <= pos_r + delta_s;
        end

        if (rise_s) begin
          per_r <= cnt_r;
          cnt_r <= 32'h0000_0001;
        end else if (cnt_r != CNT_MAX) begin
          cnt_r <= cnt_r + 32'h0000_0001;
        end

        if (dir_tog_s[i]) begin
          age_r <= 8'd0;
        end else if (age_r < DIR_MAX) begin
          age_r <= age_r + 8'd1;
        end

        err_r <= (err_r & ~bus.err_clr) | (rise_s & (age_r < DIR_MAX));
      end
    end
  end

endmodule
